mem_access: RTL
===============

// Module: mem_access
// PURPOSE
// - Memory-access (MA) stage directly downstream of the ALU. Registers the ALU result into the EX/MA boundary.
// - Drives a req/ack data-memory port for loads and stores.
// - Aligns and extends load data, and presents a single-cycle-valid writeback bundle to WB.
// - Stalls upstream while a memory transaction is outstanding. Flags misaligned accesses and bus timeouts.
// PARAMETERS
// - XLEN     32  datapath width; only 32 supported
// - TIMEOUT  16  cycles to wait for dmem_ack before a bus error; 0 = wait forever
// PORTS
// - clk            in   1     single clock, rising edge
// - rst            in   1     synchronous, active-high reset
// - ex_valid       in   1     EX presents a valid instruction this cycle
// - ex_alu_result  in   32    ALU result (dataBus_u); memory address for ld/st
// - ex_store_data  in   32    rs2 data for stores
// - ex_mem_op      in   4     memOp_e: MEM_NONE,LB,LH,LW,LBU,LHU,SB,SH,SW
// - ex_rd_addr     in   5     destination register
// - ex_reg_write   in   1     instruction writes rd
// - ma_stall       out  1     EX and earlier stages must hold
// - dmem_req       out  1     memory request, held until ack
// - dmem_we        out  1     1 = store
// - dmem_addr      out  32    word-aligned address ({addr[31:2],2'b00})
// - dmem_be        out  4     byte enables
// - dmem_wdata     out  32    store data replicated to byte lanes
// - dmem_ack       in   1     memory completes request (rdata valid same cycle)
// - dmem_rdata     in   32    raw load word
// - wb_valid       out  1     writeback bundle valid (one cycle per instr)
// - wb_reg_write   out  1     write rd
// - wb_rd_addr     out  5     destination register
// - wb_data        out  32    ALU result or formatted load data
// - ma_exc         out  1     one-cycle exception pulse
// - ma_exc_cause   out  2     EXC_LD_MISALIGN, EXC_ST_MISALIGN, EXC_BUS_ERR
// BEHAVIOUR
// - Reset values: all outputs 0. FSM returns to IDLE and the timeout counter clears. Reset mid-transaction abandons it; dmem_req is low on the cycle after the reset edge.
// - FSM states:
//   - IDLE: accepts when ex_valid && !ma_stall.
//   - BUSY: request outstanding; dmem_req=1; outputs held stable until ack.
// - Non-memory op (MEM_NONE): wb_* is registered next edge; wb_data = ex_alu_result. Latency 1, no stall.
// - Aligned load/store: IDLE->BUSY at the edge; dmem_req rises that edge.
// - On the dmem_ack cycle, the load word is formatted and wb_valid rises next edge. BUSY->IDLE.
// - A store gives wb_valid=1 with wb_reg_write=0.
// - ma_stall = (state==BUSY) && !dmem_ack, combinational. On the ack cycle the next EX instruction is accepted concurrently; back-to-back memory ops re-enter BUSY with no idle gap.
// - Load formatting uses addr[1:0]:
//   - LB/LH sign-extend the selected byte/half.
//   - LBU/LHU zero-extend.
//   - LW passes the word through.
// - Store enables:
//   - SB: be = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
//   - SH: be = 4'b0011 << addr[1:0]; wdata = {2{half}}.
//   - SW: be = 4'b1111.
// - Loads drive be = 4'b1111.
// - Misaligned access (H with addr[0], W with addr[1:0] != 0):
//   - No request is issued; no stall.
//   - Next edge: ma_exc=1 with the cause, wb_valid=1, wb_reg_write=0.
// - Timeout: a counter runs in BUSY. Reaching TIMEOUT without ack gives:
//   - dmem_req drops and state goes to IDLE;
//   - ma_exc=1 with EXC_BUS_ERR, wb_valid=1, wb_reg_write=0.
// - Counter arithmetic is unsigned $clog2(TIMEOUT+1) bits and saturates (never wraps).
// - ex_valid=0 in IDLE: wb_valid=0 next edge; no other outputs change.
// - A writeback to x0 is forwarded as given; the regfile ignores it.
// - An ack outside BUSY is ignored.
// STRUCTURE
// - riscv_definitions gains memOp_e, maExcCause_e, and the isLoad/isStore/accessSize helper functions.
// - One sub-module, load_formatter: combinational rdata + addr[1:0] + op -> wb_data.
// - Store lane/BE generation stays inline.
// TESTING
// - LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> ma_stall high 3 cycles; wb_data=0xDEADBEEF; wb_valid 1 cycle.
// - LB addr 0x103, rdata 0x80FF_FFFF -> wb_data 0xFFFFFF80. LBU at the same address -> 0x00000080.
// - SH addr 0x202, data 0x1234ABCD -> dmem_be=4'b1100, wdata 0xABCDABCD, dmem_we=1, wb_reg_write=0.
// - LW addr 0x101 -> no dmem_req; ma_exc=1 with EXC_LD_MISALIGN next edge; no stall.
// - TIMEOUT=4, no ack -> dmem_req high 4 cycles then low; EXC_BUS_ERR pulse; FSM back to IDLE.
// - LW acked with an ADD waiting in EX -> ADD is accepted on the ack cycle, wb_valid high 2 consecutive cycles. rst asserted in BUSY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - memory-access stage types and ld/st decode helpers
package mem_access_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        EXC_LD_MISALIGN = 2'd0,
        EXC_ST_MISALIGN = 2'd1,
        EXC_BUS_ERR     = 2'd2
    } ma_exc_cause_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } access_size_e;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_BUSY = 1'b1
    } ma_state_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd_addr;
        logic [31:0] data;
        logic        exc;
        logic [1:0]  cause;
    } wb_bundle_t;

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic access_size_e access_size(input mem_op_e op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return SIZE_B;
            MEM_LH, MEM_LHU, MEM_SH: return SIZE_H;
            default:                 return SIZE_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
        access_size_e sz;
        sz = access_size(op);
        return (sz == SIZE_H && addr_lo[0]) || (sz == SIZE_W && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_load_formatter.sv
// rtl/mem_access_load_formatter.sv - selects and extends the load byte/half/word
module mem_access_load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  mem_op_e     op_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (op_i)
            MEM_LB:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: data_o = {24'h0, shifted[7:0]};
            MEM_LH:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: data_o = {16'h0, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MA stage: dmem req/ack port, load formatting, writeback bundle
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [3:0]      ex_mem_op,
    input  logic [4:0]      ex_rd_addr,
    input  logic            ex_reg_write,
    output logic            ma_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            ma_exc,
    output logic [1:0]      ma_exc_cause
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    ma_state_e   state_q;
    mem_op_e     op_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic [CW-1:0] cnt_q;
    wb_bundle_t  pend_q;

    mem_op_e     ex_op;
    logic        accept, ex_is_mem, ex_misalign, launch, timeout_hit;
    logic [CW-1:0] cnt_inc;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] ld_data;
    wb_bundle_t  res_d, done_d, wb_sel, pend_d;

    assign ex_op       = mem_op_e'(ex_mem_op);
    assign ma_stall    = (state_q == MA_BUSY) && !dmem_ack;
    assign accept      = ex_valid && !ma_stall;
    assign ex_is_mem   = is_load(ex_op) || is_store(ex_op);
    assign ex_misalign = ex_is_mem && is_misaligned(ex_op, ex_alu_result[1:0]);
    assign launch      = accept && ex_is_mem && !ex_misalign;
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (state_q == MA_BUSY) && !dmem_ack && (cnt_inc == TO_VAL);

    mem_access_load_formatter u_fmt (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_lo_q),
        .op_i      (op_q),
        .data_o    (ld_data)
    );

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_store_data;
        case (ex_op)
            MEM_SB: begin
                be_d    = 4'b0001 << ex_alu_result[1:0];
                wdata_d = {4{ex_store_data[7:0]}};
            end
            MEM_SH: begin
                be_d    = 4'b0011 << ex_alu_result[1:0];
                wdata_d = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Results that finish without a memory transaction: ALU ops and misaligned accesses.
    always_comb begin
        res_d         = '0;
        res_d.rd_addr = ex_rd_addr;
        res_d.data    = ex_alu_result;
        if (accept && !ex_is_mem) begin
            res_d.valid     = 1'b1;
            res_d.reg_write = ex_reg_write;
        end else if (accept && ex_misalign) begin
            res_d.valid = 1'b1;
            res_d.exc   = 1'b1;
            res_d.cause = is_load(ex_op) ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        end
    end

    always_comb begin
        done_d         = '0;
        done_d.rd_addr = rd_q;
        done_d.data    = ld_data;
        if (state_q == MA_BUSY && dmem_ack) begin
            done_d.valid     = 1'b1;
            done_d.reg_write = rw_q && is_load(op_q);
        end else if (timeout_hit) begin
            done_d.valid = 1'b1;
            done_d.exc   = 1'b1;
            done_d.cause = EXC_BUS_ERR;
            done_d.data  = '0;
        end
    end

    // A result accepted on the ack cycle collides with the load writeback, so it
    // is parked one cycle; later results keep flowing through the park slot until
    // a bubble or a memory op drains it.
    always_comb begin
        wb_sel = res_d;
        if (done_d.valid)
            wb_sel = done_d;
        else if (pend_q.valid)
            wb_sel = pend_q;
        pend_d = (done_d.valid || pend_q.valid) ? res_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MA_IDLE;
            op_q         <= MEM_NONE;
            addr_lo_q    <= 2'b00;
            rd_q         <= 5'd0;
            rw_q         <= 1'b0;
            cnt_q        <= '0;
            pend_q       <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'b0000;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd_addr   <= 5'd0;
            wb_data      <= '0;
            ma_exc       <= 1'b0;
            ma_exc_cause <= 2'b00;
        end else begin
            pend_q <= pend_d;
            if (wb_sel.valid) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= wb_sel.reg_write;
                wb_rd_addr   <= wb_sel.rd_addr;
                wb_data      <= wb_sel.data;
                ma_exc       <= wb_sel.exc;
                if (wb_sel.exc)
                    ma_exc_cause <= wb_sel.cause;
            end else begin
                wb_valid <= 1'b0;
                ma_exc   <= 1'b0;
            end

            if (launch) begin
                state_q    <= MA_BUSY;
                op_q       <= ex_op;
                addr_lo_q  <= ex_alu_result[1:0];
                rd_q       <= ex_rd_addr;
                rw_q       <= ex_reg_write;
                cnt_q      <= '0;
                dmem_req   <= 1'b1;
                dmem_we    <= is_store(ex_op);
                dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
                dmem_be    <= be_d;
                dmem_wdata <= wdata_d;
            end else if (state_q == MA_BUSY) begin
                if (dmem_ack || timeout_hit) begin
                    state_q  <= MA_IDLE;
                    cnt_q    <= '0;
                    dmem_req <= 1'b0;
                end else begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

endmodule
